// File: rtl/twiddle_pair_collector.sv
// Collects cos/sin results from the sine/cosine LUT calculator into
// {cos, sin} twiddle pairs and buffers them in a FWFT FIFO.
module twiddle_pair_collector #(
    parameter int EXP_LEN      = 8,
    parameter int MANTISSA_LEN = 23,
    parameter int CALC_LATENCY = 3,
    parameter int FIFO_DEPTH   = 8,
    localparam int W  = EXP_LEN + MANTISSA_LEN + 1,
    localparam int AW = $clog2(FIFO_DEPTH),
    localparam int CW = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    input  logic          req_sine_cosine,
    input  logic [W-1:0]  calc_value,
    output logic          twiddle_valid,
    input  logic          twiddle_ready,
    output logic [W-1:0]  twiddle_cos,
    output logic [W-1:0]  twiddle_sin,
    output logic [CW-1:0] fifo_count,
    output logic          almost_full,
    output logic          overflow,
    output logic          pair_error
);

    typedef enum logic {
        WAIT_COS,
        WAIT_SIN
    } state_t;

    localparam logic [CW-1:0] FULL_LVL = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] AF_LVL   = CW'(FIFO_DEPTH - CALC_LATENCY);

    logic [CALC_LATENCY-1:0] tag_valid;
    logic [CALC_LATENCY-1:0] tag_sine;
    logic                    tap_valid;
    logic                    tap_sine;

    state_t         state;
    state_t         state_next;
    logic [W-1:0]   cos_hold;
    logic           latch_cos;
    logic           push;
    logic           order_err;

    logic [W-1:0]   cos_mem [FIFO_DEPTH];
    logic [W-1:0]   sin_mem [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           pop;
    logic           full;
    logic           accept;
    logic           drop;

    assign tap_valid = tag_valid[CALC_LATENCY-1];
    assign tap_sine  = tag_sine[CALC_LATENCY-1];

    // Tag delay line: re-times each request to its calculator result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_valid <= '0;
            tag_sine  <= '0;
        end else begin
            tag_valid[0] <= req_valid;
            tag_sine[0]  <= req_sine_cosine;
            for (int i = 1; i < CALC_LATENCY; i++) begin
                tag_valid[i] <= tag_valid[i-1];
                tag_sine[i]  <= tag_sine[i-1];
            end
        end
    end

    // Pairing state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= WAIT_COS;
        end else begin
            state <= state_next;
        end
    end

    // Pairing decisions for the result arriving at the tap.
    always_comb begin
        state_next = state;
        latch_cos  = 1'b0;
        push       = 1'b0;
        order_err  = 1'b0;
        if (tap_valid) begin
            unique case (state)
                WAIT_COS: begin
                    if (!tap_sine) begin
                        latch_cos  = 1'b1;
                        state_next = WAIT_SIN;
                    end else begin
                        order_err = 1'b1;
                    end
                end
                WAIT_SIN: begin
                    if (tap_sine) begin
                        push       = 1'b1;
                        state_next = WAIT_COS;
                    end else begin
                        order_err = 1'b1;
                        latch_cos = 1'b1;
                    end
                end
                default: state_next = WAIT_COS;
            endcase
        end
    end

    // Holding register for the cosine awaiting its sine.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cos_hold <= '0;
        end else if (latch_cos) begin
            cos_hold <= calc_value;
        end
    end

    assign pop    = twiddle_valid && twiddle_ready;
    assign full   = (fifo_count == FULL_LVL);
    assign accept = push && (!full || pop);
    assign drop   = push && full && !pop;

    // Pair storage; no reset needed, head is masked while empty.
    always_ff @(posedge clk) begin
        if (accept) begin
            cos_mem[wr_ptr] <= cos_hold;
            sin_mem[wr_ptr] <= calc_value;
        end
    end

    // Pointers and occupancy; pointers wrap modulo the depth.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (accept && !pop) begin
                fifo_count <= fifo_count + 1'b1;
            end else if (pop && !accept) begin
                fifo_count <= fifo_count - 1'b1;
            end
        end
    end

    // Sticky error flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow   <= 1'b0;
            pair_error <= 1'b0;
        end else begin
            if (drop) begin
                overflow <= 1'b1;
            end
            if (order_err) begin
                pair_error <= 1'b1;
            end
        end
    end

    assign twiddle_valid = (fifo_count != '0);
    assign twiddle_cos   = twiddle_valid ? cos_mem[rd_ptr] : '0;
    assign twiddle_sin   = twiddle_valid ? sin_mem[rd_ptr] : '0;
    assign almost_full   = (fifo_count >= AF_LVL);

endmodule

// File: tb/tb_twiddle_pair_collector.sv
// Randomized bench for twiddle_pair_collector with a queue-based
// reference model of the pairing and FIFO rules.
module tb_twiddle_pair_collector;

    localparam int L     = 3;
    localparam int DEPTH = 8;
    localparam int AFL   = DEPTH - L;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_sine_cosine;
    logic [31:0] calc_value;
    logic        twiddle_valid;
    logic        twiddle_ready;
    logic [31:0] twiddle_cos;
    logic [31:0] twiddle_sin;
    logic [3:0]  fifo_count;
    logic        almost_full;
    logic        overflow;
    logic        pair_error;

    twiddle_pair_collector #(
        .EXP_LEN(8), .MANTISSA_LEN(23),
        .CALC_LATENCY(L), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid),
        .req_sine_cosine(req_sine_cosine),
        .calc_value(calc_value),
        .twiddle_valid(twiddle_valid),
        .twiddle_ready(twiddle_ready),
        .twiddle_cos(twiddle_cos),
        .twiddle_sin(twiddle_sin),
        .fifo_count(fifo_count),
        .almost_full(almost_full),
        .overflow(overflow),
        .pair_error(pair_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          edge_no;
        bit          sine;
        logic [31:0] val;
    } req_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    req_t        pend[$];
    logic [63:0] mq[$];
    bit          m_have_cos;
    logic [31:0] m_cos;
    bit          m_ovf;
    bit          m_perr;

    task automatic clear_model();
        pend.delete();
        mq.delete();
        m_have_cos = 0;
        m_cos = '0;
        m_ovf = 0;
        m_perr = 0;
    endtask

    // One clock: drive inputs, advance, apply the spec rules to the model.
    task automatic step(input bit v, input bit s,
                        input logic [31:0] val, input bit rdy);
        int e;
        bit cap;
        bit do_pop;
        req_t p;
        e = cyc + 1;
        cap = (pend.size() != 0) && (pend[0].edge_no + L == e);
        req_valid = v;
        req_sine_cosine = s;
        twiddle_ready = rdy;
        calc_value = cap ? pend[0].val : 32'($urandom());
        if (v) pend.push_back('{e, s, val});
        do_pop = rdy && (mq.size() != 0);
        @(posedge clk);
        cyc++;
        if (do_pop) void'(mq.pop_front());
        if (cap) begin
            p = pend.pop_front();
            if (!p.sine) begin
                if (m_have_cos) m_perr = 1;
                m_have_cos = 1;
                m_cos = p.val;
            end else if (!m_have_cos) begin
                m_perr = 1;
            end else begin
                m_have_cos = 0;
                if (mq.size() < DEPTH) mq.push_back({m_cos, p.val});
                else m_ovf = 1;
            end
        end
        #1;
        req_valid = 0;
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(0, 0, 32'h0, rdy);
    endtask

    task automatic do_reset();
        rst = 1;
        req_valid = 0;
        twiddle_ready = 0;
        clear_model();
        repeat (2) begin
            @(posedge clk);
            cyc++;
        end
        #1;
        rst = 0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (fifo_count !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_count: got %0d want 0", fifo_count);
        end
        n_checks++;
        if ({twiddle_valid, almost_full, overflow, pair_error} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b want 0000",
                     {twiddle_valid, almost_full, overflow, pair_error});
        end
        n_checks++;
        if ({twiddle_cos, twiddle_sin} !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_head: got %h want 0", {twiddle_cos, twiddle_sin});
        end
    endtask

    task automatic test_basic_pair();
        do_reset();
        step(1, 0, 32'h3F5DB3D7, 0);
        step(1, 1, 32'h3F000000, 0);
        idle(2, 0);
        n_checks++;
        if (twiddle_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_early_valid: got %b want 0", twiddle_valid);
        end
        idle(1, 0);
        n_checks++;
        if (twiddle_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_valid: got %b want 1", twiddle_valid);
        end
        n_checks++;
        if ({twiddle_cos, twiddle_sin} !== 64'h3F5DB3D7_3F000000) begin
            n_fail++;
            $display("FAIL basic_pair: got %h_%h want 3f5db3d7_3f000000",
                     twiddle_cos, twiddle_sin);
        end
        n_checks++;
        if (fifo_count !== 4'd1) begin
            n_fail++;
            $display("FAIL basic_count: got %0d want 1", fifo_count);
        end
    endtask

    task automatic test_fill_drain();
        logic [63:0] exp_pairs[$];
        logic [31:0] c;
        logic [31:0] s;
        do_reset();
        for (int i = 0; i < 9; i++) begin
            c = $urandom();
            s = $urandom();
            if (i < 8) exp_pairs.push_back({c, s});
            step(1, 0, c, 0);
            step(1, 1, s, 0);
            if (i == 7) begin
                idle(L, 0);
                n_checks++;
                if ({fifo_count, overflow} !== {4'd8, 1'b0}) begin
                    n_fail++;
                    $display("FAIL fill_8: got cnt=%0d ovf=%b want 8 0",
                             fifo_count, overflow);
                end
            end
            n_checks++;
            if (almost_full !== (mq.size() >= AFL)) begin
                n_fail++;
                $display("FAIL fill_af: got %b want %b cnt=%0d",
                         almost_full, mq.size() >= AFL, mq.size());
            end
        end
        idle(L, 0);
        n_checks++;
        if ({fifo_count, almost_full, overflow} !== {4'd8, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL fill_overflow: got cnt=%0d af=%b ovf=%b want 8 1 1",
                     fifo_count, almost_full, overflow);
        end
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if ({twiddle_valid, twiddle_cos, twiddle_sin} !== {1'b1, exp_pairs[i]}) begin
                n_fail++;
                $display("FAIL drain_head%0d: got %b %h_%h want 1 %h",
                         i, twiddle_valid, twiddle_cos, twiddle_sin, exp_pairs[i]);
            end
            step(0, 0, 0, 1);
        end
        n_checks++;
        if ({fifo_count, twiddle_valid} !== {4'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL drain_empty: got cnt=%0d v=%b want 0 0",
                     fifo_count, twiddle_valid);
        end
    endtask

    task automatic test_full_push_pop();
        logic [31:0] c;
        logic [31:0] s;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            step(1, 0, $urandom(), 0);
            step(1, 1, $urandom(), 0);
        end
        idle(L, 0);
        c = $urandom();
        s = $urandom();
        step(1, 0, c, 0);
        step(1, 1, s, 0);
        idle(L - 1, 0);
        step(0, 0, 0, 1);
        n_checks++;
        if ({fifo_count, overflow} !== {4'd8, 1'b0}) begin
            n_fail++;
            $display("FAIL fullpp_count: got cnt=%0d ovf=%b want 8 0",
                     fifo_count, overflow);
        end
        for (int i = 0; i < 7; i++) begin
            n_checks++;
            if ({twiddle_cos, twiddle_sin} !== mq[0]) begin
                n_fail++;
                $display("FAIL fullpp_order%0d: got %h_%h want %h",
                         i, twiddle_cos, twiddle_sin, mq[0]);
            end
            step(0, 0, 0, 1);
        end
        n_checks++;
        if ({fifo_count, twiddle_cos, twiddle_sin} !== {4'd1, c, s}) begin
            n_fail++;
            $display("FAIL fullpp_last: got cnt=%0d %h_%h want 1 %h_%h",
                     fifo_count, twiddle_cos, twiddle_sin, c, s);
        end
    endtask

    task automatic test_order_errors();
        do_reset();
        step(1, 1, $urandom(), 0);
        step(1, 1, $urandom(), 0);
        idle(L, 0);
        n_checks++;
        if ({fifo_count, pair_error} !== {4'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL order_a: got cnt=%0d err=%b want 0 1",
                     fifo_count, pair_error);
        end
        do_reset();
        step(1, 0, 32'h3F800000, 0);
        step(1, 0, 32'h3F3504F3, 0);
        step(1, 1, 32'h3F3504F3, 0);
        idle(L, 0);
        n_checks++;
        if ({fifo_count, pair_error, twiddle_cos, twiddle_sin}
            !== {4'd1, 1'b1, 32'h3F3504F3, 32'h3F3504F3}) begin
            n_fail++;
            $display("FAIL order_b: got cnt=%0d err=%b %h_%h want 1 1 3f3504f3_3f3504f3",
                     fifo_count, pair_error, twiddle_cos, twiddle_sin);
        end
    endtask

    task automatic test_reset_midflight();
        do_reset();
        step(1, 0, $urandom(), 0);
        step(1, 1, $urandom(), 0);
        idle(1, 0);
        do_reset();
        idle(L + 2, 0);
        n_checks++;
        if ({fifo_count, twiddle_valid, almost_full, overflow, pair_error,
             twiddle_cos, twiddle_sin} !== '0) begin
            n_fail++;
            $display("FAIL midrst_state: got cnt=%0d v=%b af=%b ovf=%b err=%b %h_%h want all 0",
                     fifo_count, twiddle_valid, almost_full, overflow,
                     pair_error, twiddle_cos, twiddle_sin);
        end
        step(1, 0, 32'h3F800000, 0);
        step(1, 1, 32'h00000000, 0);
        idle(L, 0);
        n_checks++;
        if ({fifo_count, twiddle_cos, twiddle_sin}
            !== {4'd1, 32'h3F800000, 32'h00000000}) begin
            n_fail++;
            $display("FAIL midrst_pair: got cnt=%0d %h_%h want 1 3f800000_00000000",
                     fifo_count, twiddle_cos, twiddle_sin);
        end
    endtask

    task automatic test_gaps();
        logic [31:0] c;
        logic [31:0] s;
        c = $urandom();
        s = $urandom();
        do_reset();
        step(1, 0, c, 0);
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 0, 0);
            n_checks++;
            if (twiddle_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL gap_valid%0d: got %b want 0", i, twiddle_valid);
            end
        end
        step(1, 1, s, 0);
        idle(L, 0);
        n_checks++;
        if ({fifo_count, pair_error, twiddle_cos, twiddle_sin}
            !== {4'd1, 1'b0, c, s}) begin
            n_fail++;
            $display("FAIL gap_pair: got cnt=%0d err=%b %h_%h want 1 0 %h_%h",
                     fifo_count, pair_error, twiddle_cos, twiddle_sin, c, s);
        end
    endtask

    task automatic test_random();
        bit last_cos;
        bit v;
        bit s;
        last_cos = 0;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            v = ($urandom_range(0, 3) != 0);
            if (last_cos) s = ($urandom_range(0, 15) != 0);
            else s = ($urandom_range(0, 15) == 0);
            if (v && !s && almost_full && $urandom_range(0, 3) != 0) v = 0;
            if (v) last_cos = !s;
            step(v, s, $urandom(), ($urandom_range(0, 2) == 0));
            n_checks++;
            if ({fifo_count, twiddle_valid} !== {4'(mq.size()), mq.size() != 0}) begin
                n_fail++;
                $display("FAIL rand_count@%0d: got cnt=%0d v=%b want %0d",
                         i, fifo_count, twiddle_valid, mq.size());
            end
            if (mq.size() != 0) begin
                n_checks++;
                if ({twiddle_cos, twiddle_sin} !== mq[0]) begin
                    n_fail++;
                    $display("FAIL rand_head@%0d: got %h_%h want %h",
                             i, twiddle_cos, twiddle_sin, mq[0]);
                end
            end
            n_checks++;
            if ({almost_full, overflow, pair_error}
                !== {mq.size() >= AFL, m_ovf, m_perr}) begin
                n_fail++;
                $display("FAIL rand_flags@%0d: got %b%b%b want %b%b%b", i,
                         almost_full, overflow, pair_error,
                         mq.size() >= AFL, m_ovf, m_perr);
            end
        end
    endtask

    initial begin
        rst = 1;
        req_valid = 0;
        req_sine_cosine = 0;
        calc_value = '0;
        twiddle_ready = 0;
        #1;
        test_reset();
        test_basic_pair();
        test_fill_drain();
        test_full_push_pop();
        test_order_errors();
        test_reset_midflight();
        test_gaps();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
